// File: rtl/cpu_stack.sv
// Operand stack: pop-then-push per cycle, registered top/next-of-stack reads.
// Define CPU_STACK_CHECK_EN for depth clamping and sticky over/underflow flags.
module cpu_stack #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [2:0]               c__to_push_4a,
    input  logic [34:0]              st__to_push_4a,
    input  logic [10:0]              st__to_pop_4a,
    input  logic                     hold,
    input  logic                     err_clr,
    output logic [34:0]              r0_2a,
    output logic [34:0]              r1_2a,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = AW + 1;

    logic [34:0]   mem [DEPTH];
    logic [W-1:0]  sp;
    logic [W-1:0]  sp_pop;
    logic [W-1:0]  sp_nxt;
    logic          push;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd0_idx;
    logic [AW-1:0] rd1_idx;

`ifdef CPU_STACK_CHECK_EN
    logic ovf_now;
    logic unf_now;

    always_comb begin
        push    = (c__to_push_4a != 3'd0);
        unf_now = 1'b0;
        ovf_now = 1'b0;
        sp_pop  = sp - W'(st__to_pop_4a);
        if (32'(st__to_pop_4a) > 32'(sp)) begin
            unf_now = 1'b1;
            sp_pop  = '0;
        end
        wr_en = push;
        // A push onto a full stack is dropped rather than wrapping.
        if (push && (32'(sp_pop) == 32'(DEPTH))) begin
            ovf_now = 1'b1;
            wr_en   = 1'b0;
        end
        sp_nxt = sp_pop + {{AW{1'b0}}, wr_en};
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;

    always_comb begin
        push   = (c__to_push_4a != 3'd0);
        sp_pop = sp - W'(st__to_pop_4a);
        wr_en  = push;
        sp_nxt = sp_pop + {{AW{1'b0}}, wr_en};
    end
`endif

    assign wr_idx  = sp_pop[AW-1:0];
    assign rd0_idx = AW'(sp - W'(1));
    assign rd1_idx = AW'(sp - W'(2));

    // Storage is intentionally not reset; reads are gated by depth.
    always_ff @(posedge clk) begin
        if (!hold && wr_en) begin
            mem[wr_idx] <= st__to_push_4a;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sp    <= '0;
            depth <= '0;
            r0_2a <= '0;
            r1_2a <= '0;
        end else begin
            if (!hold) begin
                sp <= sp_nxt;
            end
            depth <= sp;
            r0_2a <= (sp != '0)     ? mem[rd0_idx] : 35'h0;
            r1_2a <= (sp > W'(1))   ? mem[rd1_idx] : 35'h0;
        end
    end

`ifdef CPU_STACK_CHECK_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~err_clr) | (!hold & ovf_now);
            underflow <= (underflow & ~err_clr) | (!hold & unf_now);
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_stack.sv
// Directed bench for cpu_stack (DEPTH=8), covers both bounds-check builds.
module tb_cpu_stack;

    logic        clk;
    logic        rst_b;
    logic [2:0]  c__to_push_4a;
    logic [34:0] st__to_push_4a;
    logic [10:0] st__to_pop_4a;
    logic        hold;
    logic        err_clr;
    logic [34:0] r0_2a;
    logic [34:0] r1_2a;
    logic [3:0]  depth;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    cpu_stack #(.DEPTH(8)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .c__to_push_4a  (c__to_push_4a),
        .st__to_push_4a (st__to_push_4a),
        .st__to_pop_4a  (st__to_pop_4a),
        .hold           (hold),
        .err_clr        (err_clr),
        .r0_2a          (r0_2a),
        .r1_2a          (r1_2a),
        .depth          (depth),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c__to_push_4a  = 3'd0;
        st__to_push_4a = 35'h0;
        st__to_pop_4a  = 11'd0;
        hold           = 1'b0;
        err_clr        = 1'b0;
    endtask

    // one committed operation followed by an idle cycle so outputs settle
    task automatic op(input logic [2:0] c, input logic [34:0] w,
                      input logic [10:0] p);
        c__to_push_4a  = c;
        st__to_push_4a = w;
        st__to_pop_4a  = p;
        tick();
        idle();
        tick();
    endtask

    task automatic do_reset();
        idle();
        rst_b = 1'b0;
        #3;
        rst_b = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        rst_b = 1'b0;
        #12;
        chk("rst_depth", 64'(depth), 64'd0);
        chk("rst_r0", 64'(r0_2a), 64'h0);
        chk("rst_r1", 64'(r1_2a), 64'h0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_unf", 64'(underflow), 64'd0);
        rst_b = 1'b1;
        tick();

        // two pushes
        op(3'd1, 35'h0_0000_0011, 11'd0);
        chk("p1_depth", 64'(depth), 64'd1);
        chk("p1_r0", 64'(r0_2a), 64'h11);
        chk("p1_r1", 64'(r1_2a), 64'h0);
        op(3'd5, 35'h0_0000_0022, 11'd0);
        chk("p2_depth", 64'(depth), 64'd2);
        chk("p2_r0", 64'(r0_2a), 64'h22);
        chk("p2_r1", 64'(r1_2a), 64'h11);

        // A,B,C then pop 2 + push D
        op(3'd7, 35'h7_0000_0033, 11'd0);
        chk("p3_depth", 64'(depth), 64'd3);
        chk("p3_r0", 64'(r0_2a), 64'h7_0000_0033);
        op(3'd2, 35'h4_0000_0044, 11'd2);
        chk("pp_depth", 64'(depth), 64'd2);
        chk("pp_r0", 64'(r0_2a), 64'h4_0000_0044);
        chk("pp_r1", 64'(r1_2a), 64'h11);

        // hold with push and pop asserted
        hold           = 1'b1;
        c__to_push_4a  = 3'd1;
        st__to_push_4a = 35'h55;
        st__to_pop_4a  = 11'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_depth", 64'(depth), 64'd2);
            chk("hold_r0", 64'(r0_2a), 64'h4_0000_0044);
            chk("hold_r1", 64'(r1_2a), 64'h11);
        end
        idle();
        tick();
        chk("unhold_depth", 64'(depth), 64'd2);

        // pop everything: gated reads
        op(3'd0, 35'h0, 11'd2);
        chk("empty_depth", 64'(depth), 64'd0);
        chk("empty_r0", 64'(r0_2a), 64'h0);
        chk("empty_r1", 64'(r1_2a), 64'h0);

        // pop beyond depth
        op(3'd1, 35'h1AB, 11'd0);
        op(3'd0, 35'h0, 11'd3);
`ifdef CPU_STACK_CHECK_EN
        chk("unf_flag", 64'(underflow), 64'd1);
        chk("unf_depth", 64'(depth), 64'd0);
        chk("unf_r0", 64'(r0_2a), 64'h0);
        err_clr = 1'b1;
        tick();
        idle();
        chk("unf_clr", 64'(underflow), 64'd0);
        // error in the same cycle as clear keeps the flag
        err_clr       = 1'b1;
        st__to_pop_4a = 11'd1;
        tick();
        idle();
        chk("unf_clr_win", 64'(underflow), 64'd1);
`else
        chk("wrap_depth", 64'(depth), 64'd14);
        chk("wrap_unf", 64'(underflow), 64'd0);
`endif
        do_reset();

        // fill 8 entries, then push onto full stack
        for (int i = 1; i <= 8; i++) begin
            c__to_push_4a  = 3'd1;
            st__to_push_4a = 35'(i);
            tick();
        end
        idle();
        tick();
        chk("full_depth", 64'(depth), 64'd8);
        chk("full_r0", 64'(r0_2a), 64'h8);
        chk("full_r1", 64'(r1_2a), 64'h7);
        op(3'd1, 35'h77, 11'd0);
`ifdef CPU_STACK_CHECK_EN
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_depth", 64'(depth), 64'd8);
        chk("ovf_r0", 64'(r0_2a), 64'h8);
        err_clr = 1'b1;
        tick();
        idle();
        chk("ovf_clr", 64'(overflow), 64'd0);
        op(3'd1, 35'h99, 11'd1);
        chk("fullpp_ovf", 64'(overflow), 64'd0);
        chk("fullpp_depth", 64'(depth), 64'd8);
        chk("fullpp_r0", 64'(r0_2a), 64'h99);
        chk("fullpp_r1", 64'(r1_2a), 64'h7);
`else
        chk("wrapo_depth", 64'(depth), 64'd9);
        chk("wrapo_r0", 64'(r0_2a), 64'h77);
        chk("wrapo_ovf", 64'(overflow), 64'd0);
        op(3'd1, 35'h99, 11'd2);
        chk("wrappp_depth", 64'(depth), 64'd8);
        chk("wrappp_r0", 64'(r0_2a), 64'h99);
        chk("wrappp_r1", 64'(r1_2a), 64'h7);
`endif
        do_reset();

        // reset in the middle of a push stream
        for (int i = 0; i < 5; i++) begin
            c__to_push_4a  = 3'd3;
            st__to_push_4a = 35'(16 + i);
            tick();
        end
        tick();
        chk("s5_depth", 64'(depth), 64'd5);
        chk("s5_r0", 64'(r0_2a), 64'h14);
        #2;
        rst_b = 1'b0;
        #1;
        chk("mrst_depth", 64'(depth), 64'd0);
        chk("mrst_r0", 64'(r0_2a), 64'h0);
        chk("mrst_r1", 64'(r1_2a), 64'h0);
        tick();
        chk("mrst_hold_depth", 64'(depth), 64'd0);
        idle();
        rst_b = 1'b1;
        tick();
        chk("post_depth", 64'(depth), 64'd0);
        op(3'd1, 35'h3_0000_00AA, 11'd0);
        chk("post_push_depth", 64'(depth), 64'd1);
        chk("post_push_r0", 64'(r0_2a), 64'h3_0000_00AA);
        chk("post_push_r1", 64'(r1_2a), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_stack.md
CPU_STACK -- requirements
Module: cpu_stack

Interface
- REQ-001: Parameter DEPTH, default 64, number of 35-bit stack entries (power of two, 4..1024).
- REQ-002: clk  input  1  clock; all state updates on rising edge.
- REQ-003: rst_b  input  1  reset, asynchronous, active-low.
- REQ-004: c__to_push_4a  input  3  push code from memory stage; 3'd0 = no push, any other value = push st__to_push_4a.
- REQ-005: st__to_push_4a  input  35  tagged word to push: [34:32] type, [31:0] data.
- REQ-006: st__to_pop_4a  input  11  unsigned count of entries to pop this cycle.
- REQ-007: hold  input  1  stall; when 1, no pop/push commits this cycle.
- REQ-008: err_clr  input  1  synchronous clear of sticky error flags.
- REQ-009: r0_2a  output  35  registered top-of-stack (entry sp-1).
- REQ-010: r1_2a  output  35  registered next-of-stack (entry sp-2).
- REQ-011: depth  output  clog2(DEPTH)+1  registered current entry count.
- REQ-012: overflow  output  1  sticky push-when-full flag.
- REQ-013: underflow  output  1  sticky pop-beyond-depth flag.

Function
- REQ-014: Per cycle with hold=0: pop applied first, then push; both commit on the same edge.
- REQ-015: Pop: new depth = depth - st__to_pop_4a; popped entry contents are not cleared.
- REQ-016: Push: write st__to_push_4a to entry at post-pop depth, then depth increments by 1.
- REQ-017: Push and pop of N in one cycle: net depth change = 1 - N; pushed word becomes r0_2a.
- REQ-018: hold=1: depth, storage, r0_2a, r1_2a unchanged; inputs ignored.
- REQ-019: r0_2a, r1_2a, depth reflect committed state one cycle after the commit edge (latency 1); no combinational input-to-output path.
- REQ-020: r0_2a = 35'h0 when depth < 1; r1_2a = 35'h0 when depth < 2.
- REQ-021: Storage is a DEPTH-entry array indexed by stack pointer; single write port, two registered reads.
- REQ-022: err_clr=1 clears overflow and underflow on next edge; an error occurring the same cycle wins (flag ends set).

Reset
- REQ-023: rst_b low: depth=0, r0_2a=35'h0, r1_2a=35'h0, overflow=0, underflow=0, immediately and asynchronously.
- REQ-024: Storage array contents are not reset; reads gated by REQ-020 hide them.
- REQ-025: Reset asserted mid-operation discards any in-flight push/pop; first commit after release sees depth=0.

Configuration
- REQ-026: Macro CPU_STACK_CHECK_EN selects bounds checking.
- REQ-027: Defined: pop count > depth sets underflow and clamps depth to 0; push with post-pop depth = DEPTH sets overflow, push dropped, depth stays DEPTH.
- REQ-028: Undefined: no clamping, pointer arithmetic wraps modulo 2*DEPTH on depth width, overflow and underflow tied to 0, err_clr ignored.

Verification
- REQ-029: Reset, push 35'h0_0000_0011 then 35'h0_0000_0022 -> after second commit +1: depth=2, r0_2a=..22, r1_2a=..11.
- REQ-030: Depth 3 (A,B,C), pop=2 with push D same cycle -> depth=2, r0_2a=D, r1_2a=A.
- REQ-031: hold=1 with push and pop=1 asserted for 3 cycles -> depth, r0_2a, r1_2a unchanged throughout.
- REQ-032: CHECK_EN, depth=1, pop=3 -> underflow=1, depth=0, r0_2a=0; err_clr next cycle -> underflow=0.
- REQ-033: CHECK_EN, DEPTH=4 filled, push 35'h7 -> overflow=1, depth=4, r0_2a unchanged; push+pop=1 when full -> no overflow, r0_2a=new word.
- REQ-034: Reset pulsed during push stream at depth 5 -> all outputs zero during reset, depth=0 after release, next push gives depth=1.
